// File: rtl/trigger_manager_mc.sv
// -----------------------------------------------------------------------------
// trigger_manager_mc
//
// Multi-channel trigger sequencer. When a trigger arrives, it asks every enabled
// channel to prepare. Once all latched channels report ready, it opens the fill
// window. Once all latched channels report done, it closes the window again.
// It also counts fills and dropped triggers, and aborts sequences that hang.
//
// Optional feature macro: TRIG_MGR_PENDING_EN
//   defined   - triggers that arrive while busy are queued in a saturating
//               pending counter; IDLE drains one entry per start.
//   undefined - every busy trigger is dropped; pending is tied to 0.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   trigger      one-cycle trigger pulse
//   chan_en      channel enable mask, latched at each start
//   ready        per-channel prepared indication
//   done         per-channel fill complete
//   prepare      request channels to prepare (PREPARE state)
//   go           fill window active (FILL state)
//   pause        pause upstream during fill (FILL state)
//   busy         sequencer not idle
//   fill_num     fills started, wraps
//   drop_count   discarded triggers, saturates at all-ones
//   pending      queued trigger count
//   timeout_err  one-cycle pulse after an aborted sequence
// -----------------------------------------------------------------------------
module trigger_manager_mc #(
   parameter int NCH     = 4,
   parameter int TIMEOUT = 65535,
   parameter int TO_W    = 16,
   parameter int CNT_W   = 24,
   parameter int PEND_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              trigger,
   input  logic [NCH-1:0]    chan_en,
   input  logic [NCH-1:0]    ready,
   input  logic [NCH-1:0]    done,
   output logic              prepare,
   output logic              go,
   output logic              pause,
   output logic              busy,
   output logic [CNT_W-1:0]  fill_num,
   output logic [CNT_W-1:0]  drop_count,
   output logic [PEND_W-1:0] pending,
   output logic              timeout_err
);

   typedef enum logic [1:0] {S_IDLE, S_PREPARE, S_FILL} state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t           r_state, w_state_next;
   logic [NCH-1:0]   r_act_mask;
   logic [TO_W-1:0]  r_to_cnt;
   logic [CNT_W-1:0] r_fill_num, r_drop_count;
   logic             r_prepare, r_go, r_busy, r_timeout_err;

   logic w_pend_nz, w_busy_drop;
   logic w_latch, w_fill_inc, w_abort, w_idle_drop, w_busy_trig, w_to_hit;
   logic w_all_ready, w_all_done;

   assign w_all_ready = ((ready & r_act_mask) == r_act_mask);
   assign w_all_done  = ((done  & r_act_mask) == r_act_mask);
   // A zero TIMEOUT turns the watchdog off entirely.
   assign w_to_hit    = (TIMEOUT != 0) && (r_to_cnt == TO_LAST);

   always_comb begin
      w_state_next = r_state;
      w_latch      = 1'b0;
      w_fill_inc   = 1'b0;
      w_abort      = 1'b0;
      w_idle_drop  = 1'b0;
      w_busy_trig  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (trigger || w_pend_nz) begin
               if (|chan_en) begin
                  w_state_next = S_PREPARE;
                  w_latch      = 1'b1;
               end else begin
                  w_idle_drop  = 1'b1;
               end
            end
         end
         S_PREPARE: begin
            w_busy_trig = trigger;
            // The exit condition takes priority over a coincident timeout.
            if (w_all_ready) begin
               w_state_next = S_FILL;
               w_fill_inc   = 1'b1;
            end else if (w_to_hit) begin
               w_state_next = S_IDLE;
               w_abort      = 1'b1;
            end
         end
         S_FILL: begin
            w_busy_trig = trigger;
            if (w_all_done) begin
               w_state_next = S_IDLE;
            end else if (w_to_hit) begin
               w_state_next = S_IDLE;
               w_abort      = 1'b1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_act_mask    <= '0;
         r_to_cnt      <= '0;
         r_fill_num    <= '0;
         r_drop_count  <= '0;
         r_prepare     <= 1'b0;
         r_go          <= 1'b0;
         r_busy        <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_prepare     <= (w_state_next == S_PREPARE);
         r_go          <= (w_state_next == S_FILL);
         r_busy        <= (w_state_next != S_IDLE);
         r_timeout_err <= w_abort;
         if (w_latch)
            r_act_mask <= chan_en;
         // The timeout counter restarts on every state entry.
         if (w_state_next != r_state)
            r_to_cnt <= '0;
         else if (r_state != S_IDLE)
            r_to_cnt <= r_to_cnt + 1'b1;
         if (w_fill_inc)
            r_fill_num <= r_fill_num + 1'b1;
         if ((w_idle_drop || w_busy_drop) && !(&r_drop_count))
            r_drop_count <= r_drop_count + 1'b1;
      end
   end

`ifdef TRIG_MGR_PENDING_EN
   logic [PEND_W-1:0] r_pending;
   logic              w_pend_full;

   assign w_pend_nz   = (r_pending != '0);
   assign w_pend_full = &r_pending;
   assign w_busy_drop = w_busy_trig && w_pend_full;

   // In IDLE, a trigger together with a queued entry consumes one entry and
   // enqueues the trigger, so the count stays the same.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_pending <= '0;
      else if (r_state == S_IDLE) begin
         if (!trigger && w_pend_nz)
            r_pending <= r_pending - 1'b1;
      end else if (trigger && !w_pend_full)
         r_pending <= r_pending + 1'b1;
   end

   assign pending = r_pending;
`else
   assign w_pend_nz   = 1'b0;
   assign w_busy_drop = w_busy_trig;
   assign pending     = '0;
`endif

   assign prepare     = r_prepare;
   assign go          = r_go;
   assign pause       = r_go;
   assign busy        = r_busy;
   assign fill_num    = r_fill_num;
   assign drop_count  = r_drop_count;
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_trigger_manager_mc.sv
// -----------------------------------------------------------------------------
// Testbench for trigger_manager_mc. The main instance (u_dut) has a long
// timeout. The second instance (u_to) has TIMEOUT=8 and shares the same
// stimulus, so it can exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_trigger_manager_mc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        trigger = 1'b0;
   logic [3:0]  chan_en = 4'h0;
   logic [3:0]  ready = 4'h0;
   logic [3:0]  done = 4'h0;

   logic        prepare, go, pause, busy, timeout_err;
   logic [23:0] fill_num, drop_count;
   logic [1:0]  pending;

   logic        to_prepare, to_go, to_pause, to_busy, to_timeout_err;
   logic [23:0] to_fill_num, to_drop_count;
   logic [1:0]  to_pending;

   int n_checks = 0;
   int n_fail   = 0;

   trigger_manager_mc #(.NCH(4), .TIMEOUT(64), .TO_W(16), .CNT_W(24), .PEND_W(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .trigger(trigger), .chan_en(chan_en),
      .ready(ready), .done(done), .prepare(prepare), .go(go), .pause(pause),
      .busy(busy), .fill_num(fill_num), .drop_count(drop_count),
      .pending(pending), .timeout_err(timeout_err)
   );

   trigger_manager_mc #(.NCH(4), .TIMEOUT(8), .TO_W(16), .CNT_W(24), .PEND_W(2)) u_to (
      .clk(clk), .rst_n(rst_n), .trigger(trigger), .chan_en(chan_en),
      .ready(ready), .done(done), .prepare(to_prepare), .go(to_go), .pause(to_pause),
      .busy(to_busy), .fill_num(to_fill_num), .drop_count(to_drop_count),
      .pending(to_pending), .timeout_err(to_timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      trigger = 1'b0; ready = 4'h0; done = 4'h0; chan_en = 4'hF;
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if ({prepare, go, pause, busy, timeout_err, fill_num, drop_count, pending} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got=%b%b%b%b%b fill=%0d drop=%0d pend=%0d exp all zero",
                  prepare, go, pause, busy, timeout_err, fill_num, drop_count, pending);
      end
      reset_dut();
      $display("test_reset done");
   endtask

   task automatic test_basic();
      reset_dut();
      trigger = 1'b1; tick(); trigger = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if ({prepare, go, pause, busy} !== 4'b1001) begin
            n_fail++;
            $display("FAIL basic_prepare step=%0d got=%b exp=1001", i, {prepare, go, pause, busy});
         end
         if (i < 4) tick();
      end
      ready = 4'hF; tick(); ready = 4'h0;
      n_checks++;
      if ({prepare, go, pause, busy} !== 4'b0111 || fill_num !== 24'd1) begin
         n_fail++;
         $display("FAIL basic_fill got=%b fill=%0d exp=0111 fill=1", {prepare, go, pause, busy}, fill_num);
      end
      for (int i = 0; i < 14; i++) tick();
      n_checks++;
      if ({prepare, go, pause, busy} !== 4'b0111) begin
         n_fail++;
         $display("FAIL basic_fill_hold got=%b exp=0111", {prepare, go, pause, busy});
      end
      done = 4'hF; tick(); done = 4'h0;
      n_checks++;
      if ({prepare, go, pause, busy} !== 4'b0000 || fill_num !== 24'd1) begin
         n_fail++;
         $display("FAIL basic_idle got=%b fill=%0d exp=0000 fill=1", {prepare, go, pause, busy}, fill_num);
      end
      $display("test_basic done");
   endtask

   task automatic test_partial_mask();
      reset_dut();
      chan_en = 4'h5;
      trigger = 1'b1; tick(); trigger = 1'b0;
      ready = 4'h5; tick(); ready = 4'h0;
      n_checks++;
      if (go !== 1'b1 || fill_num !== 24'd1) begin
         n_fail++;
         $display("FAIL partial_fill go=%b fill=%0d exp go=1 fill=1", go, fill_num);
      end
      chan_en = 4'hF;
      done = 4'h1; tick();
      n_checks++;
      if (go !== 1'b1) begin
         n_fail++;
         $display("FAIL partial_hold go=%b exp=1", go);
      end
      done = 4'h5; tick(); done = 4'h0;
      n_checks++;
      if ({go, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL partial_exit go_busy=%b exp=00", {go, busy});
      end
      $display("test_partial_mask done");
   endtask

   task automatic test_timeout();
      reset_dut();
      // PREPARE abort: prepare high for exactly 8 cycles
      trigger = 1'b1; tick(); trigger = 1'b0;
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (to_prepare !== 1'b1 || to_timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_prepare step=%0d prep=%b err=%b exp prep=1 err=0", i, to_prepare, to_timeout_err);
         end
         if (i < 7) tick();
      end
      tick();
      n_checks++;
      if ({to_prepare, to_busy, to_timeout_err} !== 3'b001 || to_fill_num !== 24'd0) begin
         n_fail++;
         $display("FAIL to_abort got=%b fill=%0d exp=001 fill=0", {to_prepare, to_busy, to_timeout_err}, to_fill_num);
      end
      tick();
      n_checks++;
      if (to_timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL to_pulse_width err=%b exp=0", to_timeout_err);
      end
      reset_dut();
      // Exit on the same cycle as the timeout: the exit wins
      trigger = 1'b1; tick(); trigger = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      ready = 4'hF; tick(); ready = 4'h0;
      n_checks++;
      if ({to_go, to_timeout_err} !== 2'b10 || to_fill_num !== 24'd1) begin
         n_fail++;
         $display("FAIL to_tie got=%b fill=%0d exp=10 fill=1", {to_go, to_timeout_err}, to_fill_num);
      end
      // FILL abort after 8 cycles
      for (int i = 0; i < 7; i++) tick();
      n_checks++;
      if (to_go !== 1'b1) begin
         n_fail++;
         $display("FAIL to_fill_hold go=%b exp=1", to_go);
      end
      tick();
      n_checks++;
      if ({to_go, to_busy, to_timeout_err} !== 3'b001 || to_fill_num !== 24'd1) begin
         n_fail++;
         $display("FAIL to_fill_abort got=%b fill=%0d exp=001 fill=1", {to_go, to_busy, to_timeout_err}, to_fill_num);
      end
      $display("test_timeout done");
   endtask

   task automatic test_busy_triggers();
      reset_dut();
      trigger = 1'b1; tick(); trigger = 1'b0;
      ready = 4'hF; tick(); ready = 4'h0;
`ifdef TRIG_MGR_PENDING_EN
      trigger = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      trigger = 1'b0;
      n_checks++;
      if (pending !== 2'd3 || drop_count !== 24'd2) begin
         n_fail++;
         $display("FAIL queue_fill pend=%0d drop=%0d exp pend=3 drop=2", pending, drop_count);
      end
      done = 4'hF; tick(); done = 4'h0;
      // Four sequences: the first start also sees a new trigger, which is enqueued.
      for (int i = 0; i < 4; i++) begin
         trigger = (i == 0);
         tick();
         trigger = 1'b0;
         n_checks++;
         if (prepare !== 1'b1 || pending !== 2'((i == 0) ? 3 : 3 - i)) begin
            n_fail++;
            $display("FAIL queue_start seq=%0d prep=%b pend=%0d exp prep=1 pend=%0d",
                     i, prepare, pending, (i == 0) ? 3 : 3 - i);
         end
         ready = 4'hF; tick(); ready = 4'h0;
         done = 4'hF; tick(); done = 4'h0;
      end
      tick(); tick();
      n_checks++;
      if (busy !== 1'b0 || pending !== 2'd0 || fill_num !== 24'd5) begin
         n_fail++;
         $display("FAIL queue_drained busy=%b pend=%0d fill=%0d exp busy=0 pend=0 fill=5", busy, pending, fill_num);
      end
`else
      trigger = 1'b1; tick(); tick(); trigger = 1'b0;
      n_checks++;
      if (pending !== 2'd0 || drop_count !== 24'd2) begin
         n_fail++;
         $display("FAIL nopend_drop pend=%0d drop=%0d exp pend=0 drop=2", pending, drop_count);
      end
      done = 4'hF; tick(); done = 4'h0;
      tick(); tick();
      n_checks++;
      if (busy !== 1'b0 || fill_num !== 24'd1) begin
         n_fail++;
         $display("FAIL nopend_idle busy=%b fill=%0d exp busy=0 fill=1", busy, fill_num);
      end
`endif
      chan_en = 4'h0;
      trigger = 1'b1; tick(); trigger = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || drop_count !== 24'd3) begin
         n_fail++;
         $display("FAIL zero_mask_drop busy=%b drop=%0d exp busy=0 drop=3", busy, drop_count);
      end
      chan_en = 4'hF;
      $display("test_busy_triggers done");
   endtask

   task automatic test_reset_mid_fill();
      reset_dut();
      trigger = 1'b1; tick(); trigger = 1'b0;
      ready = 4'hF; tick(); ready = 4'h0;
      trigger = 1'b1; tick(); tick(); trigger = 1'b0;
`ifdef TRIG_MGR_PENDING_EN
      n_checks++;
      if (pending !== 2'd2 || go !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_pre pend=%0d go=%b exp pend=2 go=1", pending, go);
      end
`else
      n_checks++;
      if (drop_count !== 24'd2 || go !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_pre drop=%0d go=%b exp drop=2 go=1", drop_count, go);
      end
`endif
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({prepare, go, pause, busy, timeout_err, fill_num, drop_count, pending} !== '0) begin
         n_fail++;
         $display("FAIL rst_async got=%b%b%b%b%b fill=%0d drop=%0d pend=%0d exp all zero",
                  prepare, go, pause, busy, timeout_err, fill_num, drop_count, pending);
      end
      tick();
      rst_n = 1'b1;
      tick();
      trigger = 1'b1; tick(); trigger = 1'b0;
      n_checks++;
      if ({prepare, go, busy} !== 3'b101) begin
         n_fail++;
         $display("FAIL rst_restart got=%b exp=101", {prepare, go, busy});
      end
      ready = 4'hF; tick(); ready = 4'h0;
      done = 4'hF; tick(); done = 4'h0;
      n_checks++;
      if (busy !== 1'b0 || fill_num !== 24'd1) begin
         n_fail++;
         $display("FAIL rst_seq busy=%b fill=%0d exp busy=0 fill=1", busy, fill_num);
      end
      $display("test_reset_mid_fill done");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_partial_mask();
      test_timeout();
      test_busy_triggers();
      test_reset_mid_fill();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
